// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte producers.
// The winner's byte is latched when it is granted. The arbiter then follows the
// transmitter's tx_done handshake through the frame and ends with a one-cycle
// ack to the owner. err accompanies ack when tx_start timed out.
module uart_tx_arbiter #(
  parameter int unsigned N             = 4,
  parameter int unsigned START_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
  output logic [N-1:0]   ack,
  output logic           err,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_done
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  // Last counter value before tx_start has been high for START_TIMEOUT cycles
  localparam logic [15:0] CntLast = 16'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitDone,
    StAck
  } state_e;

  state_e        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [15:0]   cnt;
  logic          abort;

  logic          found;
  logic [IW-1:0] win;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  owner_oh;
  logic [7:0]    win_byte;
  logic [IW-1:0] ptr_next;

  // Rotating priority scan: first set req bit at or after ptr, wrapping mod N
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // One-hot forms, selected byte and the post-transfer pointer
  always_comb begin
    win_oh   = N'(1) << win;
    owner_oh = N'(1) << owner;
    win_byte = data[{win, 3'b000} +: 8];
    ptr_next = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
  end

  // Transfer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      abort    <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      // ack/err are single-cycle pulses, raised only on entry to StAck
      ack <= '0;
      err <= 1'b0;
      unique case (state)
        StIdle: begin
          // A low tx_done means the transmitter is still busy, so nothing is granted
          if (tx_done && found) begin
            owner    <= win;
            tx_data  <= win_byte;
            grant    <= win_oh;
            busy     <= 1'b1;
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= StStart;
          end
        end
        StStart: begin
          cnt <= cnt + 16'd1;
          if (!tx_done) begin
            tx_start <= 1'b0;
            state    <= StWaitDone;
          end else if (cnt == CntLast) begin
            tx_start <= 1'b0;
            abort    <= 1'b1;
            ack      <= owner_oh;
            err      <= 1'b1;
            state    <= StAck;
          end
        end
        StWaitDone: begin
          // Frame length is fixed by the baud rate, so this wait has no timeout
          if (tx_done) begin
            ack   <= owner_oh;
            err   <= abort;
            state <= StAck;
          end
        end
        StAck: begin
          grant <= '0;
          busy  <= 1'b0;
          abort <= 1'b0;
          ptr   <= ptr_next;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
